// File: rtl/uart_pkg.sv
// Shared UART constants: one-hot TX frame states, data-bit indices and
// parity method/enable encodings.
package uart_pkg;

  typedef enum logic [4:0] {
    INTERVAL  = 5'b0_0001,
    STARTBIT  = 5'b0_0010,
    DATABITS  = 5'b0_0100,
    PARITYBIT = 5'b0_1000,
    STOPBIT   = 5'b1_0000
  } frame_state_e;

  typedef enum logic [3:0] {
    BIT0 = 4'd0,
    BIT1 = 4'd1,
    BIT2 = 4'd2,
    BIT3 = 4'd3,
    BIT4 = 4'd4,
    BIT5 = 4'd5,
    BIT6 = 4'd6,
    BIT7 = 4'd7
  } bit_index_e;

  typedef enum logic {
    EVEN = 1'b0,
    ODD  = 1'b1
  } parity_method_e;

  typedef enum logic {
    DISABLE = 1'b0,
    ENABLE  = 1'b1
  } parity_enable_e;

endpackage

// File: rtl/uart_tx_frame_ctrl_if.sv
// Host-side byte handshake into the TX frame sequencer, with the per-byte
// parity controls that travel alongside the data.
interface uart_tx_frame_ctrl_if;
  logic       TxValid_i;
  logic [7:0] TxData_i;
  logic       TxReady_o;
  logic       ParityEnable_i;
  logic       ParityMethod_i;

  modport master (
    output TxValid_i,
    output TxData_i,
    output ParityEnable_i,
    output ParityMethod_i,
    input  TxReady_o
  );

  modport slave (
    input  TxValid_i,
    input  TxData_i,
    input  ParityEnable_i,
    input  ParityMethod_i,
    output TxReady_o
  );
endinterface

// File: rtl/uart_tx_frame_ctrl.sv
// UART transmit frame sequencer: start, 8 data bits LSB first, optional parity, STOP_BITS stop bits.
// Optional line-break generation is built when UART_TX_BREAK_EN is defined.
module uart_tx_frame_ctrl
  import uart_pkg::*;
#(
  parameter int STOP_BITS = 1  // 1 or 2
) (
  input  logic                 clk,
  input  logic                 rst,
  uart_tx_frame_ctrl_if.slave  tx_bus,
  input  logic                 p_BaudSig_i,
`ifdef UART_TX_BREAK_EN
  input  logic                 BreakReq_i,
`endif
  input  logic                 ParityResult_i,
  output logic                 ParityMethod_o,
  output logic [4:0]           State_o,
  output logic [3:0]           BitCounter_o,
  output logic [7:0]           ShiftData_o,
  output logic                 Tx_o,
  output logic                 Busy_o,
  output logic                 TxDone_o
);

  localparam logic STOP_LAST = 1'(STOP_BITS - 1);

  frame_state_e state_q, state_d;
  logic [3:0]   bit_cnt_q, bit_cnt_d;
  logic         stop_cnt_q, stop_cnt_d;
  logic [7:0]   data_q, data_d;
  logic         par_en_q, par_en_d;
  logic         par_meth_q, par_meth_d;
  logic         pending_q, pending_d;
  logic         tx_q, tx_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;
  logic         brk_q, brk_d;
  logic         xfer;

  // Ready comes from registered state only, so it never depends on TxValid_i.
  assign tx_bus.TxReady_o = (state_q == INTERVAL) && !pending_q && !brk_q;
  assign xfer             = tx_bus.TxValid_i && tx_bus.TxReady_o;

  assign State_o        = state_q;
  assign BitCounter_o   = bit_cnt_q;
  assign ShiftData_o    = data_q;
  assign ParityMethod_o = par_meth_q;
  assign Tx_o           = tx_q;
  assign Busy_o         = busy_q;
  assign TxDone_o       = done_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= INTERVAL;
      bit_cnt_q  <= BIT0;
      stop_cnt_q <= 1'b0;
      data_q     <= 8'h00;
      par_en_q   <= DISABLE;
      par_meth_q <= EVEN;
      pending_q  <= 1'b0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      brk_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      data_q     <= data_d;
      par_en_q   <= par_en_d;
      par_meth_q <= par_meth_d;
      pending_q  <= pending_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      brk_q      <= brk_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    data_d     = data_q;
    par_en_d   = par_en_q;
    par_meth_d = par_meth_q;
    pending_d  = pending_q;
    tx_d       = tx_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    brk_d      = brk_q;

    // The byte is held unshifted until the next accept so the parity generator sees stable data.
    if (xfer) begin
      data_d     = tx_bus.TxData_i;
      par_en_d   = tx_bus.ParityEnable_i;
      par_meth_d = tx_bus.ParityMethod_i;
      pending_d  = 1'b1;
      busy_d     = 1'b1;
    end

`ifdef UART_TX_BREAK_EN
    if ((state_q == INTERVAL) && !pending_q && !xfer) begin
      brk_d = BreakReq_i;
      tx_d  = !BreakReq_i;
    end
`endif

    if (p_BaudSig_i) begin
      case (state_q)
        INTERVAL: begin
          if (pending_q) begin
            state_d   = STARTBIT;
            tx_d      = 1'b0;
            pending_d = 1'b0;
            bit_cnt_d = BIT0;
          end
        end
        STARTBIT: begin
          state_d   = DATABITS;
          bit_cnt_d = BIT0;
          tx_d      = data_q[0];
        end
        DATABITS: begin
          if (bit_cnt_q != BIT7) begin
            bit_cnt_d = bit_cnt_q + 4'd1;
            tx_d      = data_q[bit_cnt_q[2:0] + 3'd1];
          end else begin
            bit_cnt_d = BIT0;
            if (par_en_q) begin
              state_d = PARITYBIT;
              tx_d    = ParityResult_i;
            end else begin
              state_d    = STOPBIT;
              tx_d       = 1'b1;
              stop_cnt_d = 1'b0;
            end
          end
        end
        PARITYBIT: begin
          state_d    = STOPBIT;
          tx_d       = 1'b1;
          stop_cnt_d = 1'b0;
        end
        STOPBIT: begin
          if (stop_cnt_q == STOP_LAST) begin
            state_d = INTERVAL;
            tx_d    = 1'b1;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            stop_cnt_d = stop_cnt_q + 1'b1;
          end
        end
        default: begin
          state_d   = INTERVAL;
          bit_cnt_d = BIT0;
          tx_d      = 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_frame_ctrl.sv
// Self-checking bench for uart_tx_frame_ctrl: randomized frames against a bit-sequence model.
// Break tests are compiled in when UART_TX_BREAK_EN is defined.
module tb_uart_tx_frame_ctrl;

  localparam int STOP_BITS_TB = 2;
  localparam logic [4:0] S_INTERVAL = 5'b0_0001;
  localparam logic [4:0] S_START    = 5'b0_0010;
  localparam logic [4:0] S_DATA     = 5'b0_0100;
  localparam logic [4:0] S_PARITY   = 5'b0_1000;
  localparam logic [4:0] S_STOP     = 5'b1_0000;

  typedef bit bitq_t[$];

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tick = 1'b0;
  logic       par_res = 1'b0;
`ifdef UART_TX_BREAK_EN
  logic       brk = 1'b0;
`endif
  logic       par_meth_out;
  logic [4:0] state;
  logic [3:0] bit_cnt;
  logic [7:0] shift_data;
  logic       tx;
  logic       busy;
  logic       done;

  int vectors     = 0;
  int miscompares = 0;
  int done_cnt    = 0;

  uart_tx_frame_ctrl_if bus();

  uart_tx_frame_ctrl #(.STOP_BITS(STOP_BITS_TB)) dut (
    .clk           (clk),
    .rst           (rst),
    .tx_bus        (bus),
    .p_BaudSig_i   (tick),
`ifdef UART_TX_BREAK_EN
    .BreakReq_i    (brk),
`endif
    .ParityResult_i(par_res),
    .ParityMethod_o(par_meth_out),
    .State_o       (state),
    .BitCounter_o  (bit_cnt),
    .ShiftData_o   (shift_data),
    .Tx_o          (tx),
    .Busy_o        (busy),
    .TxDone_o      (done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (done === 1'b1) done_cnt++;

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: time limit reached, vectors %0d miscompares %0d", vectors, miscompares);
    $fatal(1, "[TB] watchdog");
  end

  // Line sequence of one frame: start, data LSB first, optional parity, stop bits.
  function automatic bitq_t frame_bits(input logic [7:0] d, input bit pen, input bit meth);
    bitq_t q;
    q.push_back(1'b0);
    for (int i = 0; i < 8; i++) q.push_back(d[i]);
    if (pen) q.push_back((^d) ^ meth);
    for (int s = 0; s < STOP_BITS_TB; s++) q.push_back(1'b1);
    return q;
  endfunction

  task automatic do_accept(input logic [7:0] d, input bit pen, input bit meth,
                           input bit hold, input bit tick_same, input string name);
    int waited = 0;
    bus.TxValid_i      = 1'b1;
    bus.TxData_i       = d;
    bus.ParityEnable_i = pen;
    bus.ParityMethod_i = meth;
    while (bus.TxReady_o !== 1'b1 && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    vectors++;
    if (bus.TxReady_o !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL %s accept_timeout: ready %b, want 1", name, bus.TxReady_o);
      bus.TxValid_i = 1'b0;
      return;
    end
    tick = tick_same;
    @(negedge clk);
    tick = 1'b0;
    if (!hold) bus.TxValid_i = 1'b0;
    vectors++;
    if (busy !== 1'b1) begin miscompares++; $display("[TB] FAIL %s accept_busy: got %b want 1", name, busy); end
    vectors++;
    if (bus.TxReady_o !== 1'b0) begin miscompares++; $display("[TB] FAIL %s accept_ready: got %b want 0", name, bus.TxReady_o); end
    vectors++;
    if (shift_data !== d) begin miscompares++; $display("[TB] FAIL %s accept_data: got %h want %h", name, shift_data, d); end
    vectors++;
    if (par_meth_out !== meth) begin miscompares++; $display("[TB] FAIL %s accept_method: got %b want %b", name, par_meth_out, meth); end
    vectors++;
    if (state !== S_INTERVAL || tx !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL %s accept_idle: state %b tx %b, want %b tx 1", name, state, tx, S_INTERVAL);
    end
  endtask

  task automatic drive_frame(input logic [7:0] d, input bit pen, input bit meth,
                             input int period, input int max_ticks, input string name);
    bitq_t      bits;
    int         n;
    logic       exp_tx;
    logic [4:0] exp_state;
    logic [3:0] exp_cnt;
    bits    = frame_bits(d, pen, meth);
    n       = bits.size();
    par_res = (^d) ^ meth;
    for (int j = 0; j <= n && j < max_ticks; j++) begin
      repeat (period - 1) @(negedge clk);
      if (j == 0) begin
        vectors++;
        if (state !== S_INTERVAL || tx !== 1'b1) begin
          miscompares++;
          $display("[TB] FAIL %s pre_start: state %b tx %b, want %b tx 1", name, state, tx, S_INTERVAL);
        end
      end
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
      exp_tx = (j < n) ? bits[j] : 1'b1;
      if (j == n)              exp_state = S_INTERVAL;
      else if (j == 0)         exp_state = S_START;
      else if (j <= 8)         exp_state = S_DATA;
      else if (j == 9 && pen)  exp_state = S_PARITY;
      else                     exp_state = S_STOP;
      exp_cnt = (j >= 1 && j <= 8) ? 4'(j - 1) : 4'd0;
      vectors++;
      if (tx !== exp_tx) begin miscompares++; $display("[TB] FAIL %s tx[%0d]: got %b want %b", name, j, tx, exp_tx); end
      vectors++;
      if (state !== exp_state) begin miscompares++; $display("[TB] FAIL %s state[%0d]: got %b want %b", name, j, state, exp_state); end
      vectors++;
      if (bit_cnt !== exp_cnt) begin miscompares++; $display("[TB] FAIL %s bitcnt[%0d]: got %0d want %0d", name, j, bit_cnt, exp_cnt); end
      vectors++;
      if (shift_data !== d) begin miscompares++; $display("[TB] FAIL %s hold[%0d]: got %h want %h", name, j, shift_data, d); end
      vectors++;
      if (busy !== (j < n)) begin miscompares++; $display("[TB] FAIL %s busy[%0d]: got %b want %b", name, j, busy, (j < n)); end
      vectors++;
      if (done !== (j == n)) begin miscompares++; $display("[TB] FAIL %s done[%0d]: got %b want %b", name, j, done, (j == n)); end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    vectors++;
    if (tx !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_tx: got %b want 1", tx); end
    vectors++;
    if (state !== S_INTERVAL) begin miscompares++; $display("[TB] FAIL reset_state: got %b want %b", state, S_INTERVAL); end
    vectors++;
    if (bit_cnt !== 4'd0) begin miscompares++; $display("[TB] FAIL reset_bitcnt: got %0d want 0", bit_cnt); end
    vectors++;
    if (shift_data !== 8'h00) begin miscompares++; $display("[TB] FAIL reset_data: got %h want 00", shift_data); end
    vectors++;
    if (bus.TxReady_o !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_ready: got %b want 1", bus.TxReady_o); end
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_busy_done: got %b%b want 00", busy, done); end
    vectors++;
    if (par_meth_out !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_method: got %b want 0", par_meth_out); end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_even_parity();
    int d0 = done_cnt;
    do_accept(8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, "even_a5");
    drive_frame(8'hA5, 1'b1, 1'b0, 16, 100, "even_a5");
    @(negedge clk);
    vectors++;
    if (done_cnt !== d0 + 1) begin miscompares++; $display("[TB] FAIL even_a5 done_pulses: got %0d want 1", done_cnt - d0); end
  endtask

  task automatic test_odd_and_no_parity();
    int d0 = done_cnt;
    do_accept(8'h01, 1'b1, 1'b1, 1'b0, 1'b0, "odd_01");
    drive_frame(8'h01, 1'b1, 1'b1, 16, 100, "odd_01");
    do_accept(8'h01, 1'b0, 1'b1, 1'b0, 1'b0, "nopar_01");
    drive_frame(8'h01, 1'b0, 1'b1, 16, 100, "nopar_01");
    @(negedge clk);
    vectors++;
    if (done_cnt !== d0 + 2) begin miscompares++; $display("[TB] FAIL odd_nopar done_pulses: got %0d want 2", done_cnt - d0); end
  endtask

  task automatic test_random_frames();
    logic [7:0] d;
    bit         pen, meth;
    int         period;
    int         d0 = done_cnt;
    for (int k = 0; k < 6; k++) begin
      d      = 8'($urandom);
      pen    = 1'($urandom);
      meth   = 1'($urandom);
      period = $urandom_range(1, 20);
      do_accept(d, pen, meth, 1'b0, 1'b0, "random");
      drive_frame(d, pen, meth, period, 100, "random");
    end
    @(negedge clk);
    vectors++;
    if (done_cnt !== d0 + 6) begin miscompares++; $display("[TB] FAIL random done_pulses: got %0d want 6", done_cnt - d0); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] b[3];
    bit         p[3], m[3];
    int         d0 = done_cnt;
    for (int k = 0; k < 3; k++) begin
      b[k] = 8'($urandom);
      p[k] = 1'($urandom);
      m[k] = 1'($urandom);
    end
    for (int k = 0; k < 3; k++) begin
      if (k > 0) begin
        vectors++;
        if (bus.TxReady_o !== 1'b1) begin miscompares++; $display("[TB] FAIL b2b ready_after_end: got %b want 1", bus.TxReady_o); end
      end
      do_accept(b[k], p[k], m[k], k < 2, 1'b0, "b2b");
      if (k > 0) begin
        vectors++;
        if (done_cnt !== d0 + k) begin miscompares++; $display("[TB] FAIL b2b done_pulses: got %0d want %0d", done_cnt - d0, k); end
      end
      if (k < 2) begin
        bus.TxData_i       = b[k+1];
        bus.ParityEnable_i = p[k+1];
        bus.ParityMethod_i = m[k+1];
      end
      drive_frame(b[k], p[k], m[k], 12, 100, "b2b");
    end
    @(negedge clk);
    vectors++;
    if (done_cnt !== d0 + 3) begin miscompares++; $display("[TB] FAIL b2b total_done: got %0d want 3", done_cnt - d0); end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] d = 8'($urandom) | 8'h01;
    int         d0;
    do_accept(d, 1'b1, 1'b1, 1'b0, 1'b0, "rst_mid");
    drive_frame(d, 1'b1, 1'b1, 12, 6, "rst_mid");
    d0  = done_cnt;
    rst = 1'b0;
    @(negedge clk);
    vectors++;
    if (tx !== 1'b1) begin miscompares++; $display("[TB] FAIL rst_mid tx: got %b want 1", tx); end
    vectors++;
    if (state !== S_INTERVAL) begin miscompares++; $display("[TB] FAIL rst_mid state: got %b want %b", state, S_INTERVAL); end
    vectors++;
    if (bus.TxReady_o !== 1'b1) begin miscompares++; $display("[TB] FAIL rst_mid ready: got %b want 1", bus.TxReady_o); end
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_mid busy_done: got %b%b want 00", busy, done); end
    vectors++;
    if (bit_cnt !== 4'd0 || shift_data !== 8'h00 || par_meth_out !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL rst_mid regs: cnt %0d data %h method %b, want 0 00 0", bit_cnt, shift_data, par_meth_out);
    end
    rst = 1'b1;
    for (int t = 0; t < 3; t++) begin
      repeat (4) @(negedge clk);
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
      vectors++;
      if (state !== S_INTERVAL || tx !== 1'b1) begin
        miscompares++;
        $display("[TB] FAIL rst_mid idle_after: state %b tx %b, want %b tx 1", state, tx, S_INTERVAL);
      end
    end
    @(negedge clk);
    vectors++;
    if (done_cnt !== d0) begin miscompares++; $display("[TB] FAIL rst_mid no_done: got %0d pulses want 0", done_cnt - d0); end
  endtask

  task automatic test_tick_on_accept();
    logic [7:0] d = 8'($urandom);
    bit         pen = 1'($urandom);
    int         d0 = done_cnt;
    do_accept(d, pen, 1'b0, 1'b0, 1'b1, "tick_acc");
    drive_frame(d, pen, 1'b0, 10, 100, "tick_acc");
    @(negedge clk);
    vectors++;
    if (done_cnt !== d0 + 1) begin miscompares++; $display("[TB] FAIL tick_acc done_pulses: got %0d want 1", done_cnt - d0); end
  endtask

`ifdef UART_TX_BREAK_EN
  task automatic test_break();
    int bad = 0;
    brk = 1'b1;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (c % 7 == 3) begin
        tick = 1'b1;
      end else begin
        tick = 1'b0;
      end
      vectors++;
      if (tx !== 1'b0 || bus.TxReady_o !== 1'b0) begin
        miscompares++;
        bad++;
        if (bad < 4) $display("[TB] FAIL break_hold[%0d]: tx %b ready %b, want 0 0", c, tx, bus.TxReady_o);
      end
    end
    tick = 1'b0;
    brk  = 1'b0;
    @(negedge clk);
    vectors++;
    if (tx !== 1'b1 || bus.TxReady_o !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL break_release: tx %b ready %b, want 1 1", tx, bus.TxReady_o);
    end
    do_accept(8'h3C, 1'b1, 1'b0, 1'b0, 1'b0, "break_3c");
    drive_frame(8'h3C, 1'b1, 1'b0, 16, 100, "break_3c");
  endtask
`endif

  initial begin
    bus.TxValid_i      = 1'b0;
    bus.TxData_i       = 8'h00;
    bus.ParityEnable_i = 1'b0;
    bus.ParityMethod_i = 1'b0;
    test_reset();
    test_even_parity();
    test_odd_and_no_parity();
    test_tick_on_accept();
    test_back_to_back();
    test_random_frames();
    test_reset_mid_frame();
`ifdef UART_TX_BREAK_EN
    test_break();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_tx_frame_ctrl.md
# uart_tx_frame_ctrl

Transmit-side frame sequencer for the UART core. Accepts one byte per valid/ready handshake, walks the one-hot frame state (INTERVAL, STARTBIT, DATABITS, PARITYBIT, STOPBIT) on baud ticks, and drives the serial line. It exports `State_o`, `BitCounter_o`, the held byte and the parity method to the parity generator, and takes the parity result back. It sits between the host-side TX buffer and the pad, alongside the baud-rate generator.

## Interface
- STOP_BITS, 1: stop-bit periods per frame; legal values 1 or 2.
- clk  in  1  system clock, at least 40 MHz.
- rst  in  1  synchronous, active-low reset.
- p_BaudSig_i  in  1  baud tick, a one-cycle pulse per bit period.
- TxValid_i  in  1  byte available.
- TxData_i  in  8  byte to send, LSB first.
- TxReady_o  out  1  block can accept a byte; a transfer occurs when TxValid_i and TxReady_o are both high at a clk edge.
- ParityEnable_i  in  1  parity bit inserted when 1; sampled at accept.
- ParityMethod_i  in  1  0 = even, 1 = odd; sampled at accept.
- ParityResult_i  in  1  parity bit from the parity generator.
- ParityMethod_o  out  1  latched method, forwarded to the parity generator.
- State_o  out  5  one-hot frame state.
- BitCounter_o  out  4  current data-bit index, 0..7.
- ShiftData_o  out  8  latched byte; stable for the whole frame.
- Tx_o  out  1  serial line; idle level is 1.
- Busy_o  out  1  high from accept until the frame ends.
- TxDone_o  out  1  one-cycle pulse at the end of the frame.

## Operation
- States: INTERVAL = 5'b0_0001, STARTBIT = 5'b0_0010, DATABITS = 5'b0_0100, PARITYBIT = 5'b0_1000, STOPBIT = 5'b1_0000.
- **Accept.** In INTERVAL with no byte pending, TxReady_o = 1. On a transfer:
  - TxData_i, ParityEnable_i and ParityMethod_i are latched.
  - The pending flag is set; TxReady_o drops on the next cycle.
  - Busy_o rises on the next cycle.
- **Tick-driven transitions.** All transitions below occur only on a p_BaudSig_i edge.
  - INTERVAL & pending → STARTBIT; Tx_o = 0; pending is cleared.
  - STARTBIT → DATABITS; BitCounter_o = 0; Tx_o = ShiftData_o[0].
  - DATABITS with BitCounter_o < 7 → increment BitCounter_o; Tx_o = ShiftData_o[new index].
  - DATABITS with BitCounter_o == 7 → PARITYBIT if parity is enabled (Tx_o = ParityResult_i), else STOPBIT (Tx_o = 1).
  - PARITYBIT → STOPBIT; Tx_o = 1.
  - STOPBIT, after STOP_BITS tick periods → INTERVAL; TxDone_o = 1 for that cycle; Busy_o = 0.
- **Data hold.** ShiftData_o is never shifted. It is held from accept until the next accept, so the parity generator's capture at the end of bit 0 sees stable data.
- BitCounter_o returns to 0 on entry to every state other than DATABITS.
- **Back-to-back frames.** An accept is possible on the cycle after the return to INTERVAL. The next tick then starts STARTBIT, giving at least one full idle period between frames.
- **Tick during the accept cycle.** A tick in the same cycle as an accept does not start the frame; the frame starts on the following tick.
- **Consecutive ticks.** Ticks on consecutive cycles are legal; each one advances exactly one bit.
- **Reset mid-frame.** Applying rst low mid-frame aborts the frame. At the next edge all outputs take their reset values and no TxDone_o pulse is issued.
- **Reset values.**
  - State_o = 5'b0_0001, BitCounter_o = 0, ShiftData_o = 8'h00.
  - Tx_o = 1, TxReady_o = 1, Busy_o = 0, TxDone_o = 0, ParityMethod_o = 0.

## Timing
- State_o, BitCounter_o, Tx_o, TxDone_o, Busy_o and ParityMethod_o are registered and update in the cycle after the clk edge that samples the tick or the accept.
- TxReady_o is decoded from registered state only; it has no combinational path from TxValid_i.
- Frame length is 10 + P + (STOP_BITS − 1) bit periods, where P = 1 with parity and 0 without.
- Latency from accept to start bit is at most one tick period plus one cycle.

## Configuration
- **UART_TX_BREAK_EN defined:**
  - Adds input `BreakReq_i`.
  - In INTERVAL with nothing pending, BreakReq_i = 1 forces Tx_o = 0 and TxReady_o = 0 from the next cycle.
  - On release, Tx_o = 1 on the next cycle and accepts resume.
  - BreakReq_i is ignored during a frame.
- **UART_TX_BREAK_EN undefined:** no `BreakReq_i` port; the idle line is always 1.

## Structure
- **Shared package `uart_pkg`:**
  - State encodings INTERVAL through STOPBIT.
  - BIT0–BIT7 indices.
  - EVEN/ODD and ENABLE/DISABLE constants.
- **No sub-module.** The parity generator is instantiated beside this block by the TX top, not inside it.

## Test plan
- **Basic frame, even parity.** Send 0xA5, parity enabled, even, with tick every 16 cycles. Tx_o must read 0,1,0,1,0,0,1,0,1,0(parity),1; TxDone_o pulses once.
- **Odd parity, no parity.** Send 0x01 with odd parity: parity bit = 0. Send 0x01 with parity disabled: the frame is 10 bits with no PARITYBIT state visited.
- **Back-to-back frames.** Hold TxValid_i high for 3 bytes with STOP_BITS = 2. Exactly one idle period must separate frames, and ShiftData_o changes only at accept.
- **Reset mid-frame.** Assert rst low during bit 4. The next cycle shows Tx_o = 1, State_o = 5'b0_0001, TxReady_o = 1, and no TxDone_o pulse.
- **Tick on accept cycle.** Tick in the same cycle as the accept: STARTBIT begins only on the next tick.
- **Break (UART_TX_BREAK_EN).** BreakReq_i held for 50 cycles: Tx_o = 0 and TxReady_o = 0 throughout. After release, a byte of 0x3C is sent correctly.
